// File: rtl/aes_round_sequencer_if.sv
// Control/handshake bundle between the AES top-level controller and the round sequencer.
// master = controller side, slave = sequencer side.
interface aes_round_sequencer_if;
    logic       start;
    logic       opt_mode;
    logic       key_ready;
    logic       abort;
    logic       out_ready;
    logic       busy;
    logic       load_state;
    logic       round_en;
    logic [1:0] col_sel;
    logic [3:0] round_idx;
    logic [3:0] key_idx;
    logic       final_round;
    logic       out_valid;
    logic       enc_done;
    logic       start_err;

    modport master (
        output start, opt_mode, key_ready, abort, out_ready,
        input  busy, load_state, round_en, col_sel, round_idx, key_idx,
               final_round, out_valid, enc_done, start_err
    );

    modport slave (
        input  start, opt_mode, key_ready, abort, out_ready,
        output busy, load_state, round_en, col_sel, round_idx, key_idx,
               final_round, out_valid, enc_done, start_err
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round scheduler: waits for the key schedule, issues the initial load,
// steps the column-serial datapath through NUM_ROUNDS rounds and holds the result.
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS   = 10,
    parameter int unsigned ROUND_CYCLES = 4
) (
    input logic                 clk,
    input logic                 n_rst,
    aes_round_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_WAIT,
        S_LOAD,
        S_ROUND,
        S_HOLD
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [1:0] LAST_COL   = 2'(ROUND_CYCLES - 1);

    state_t     state;
    logic [3:0] round_cnt;
    logic [1:0] col_cnt;
    logic       mode_q;
    logic       start_err_q;
    logic       done_pend;
    logic       accept_start;

    // Start is taken only from IDLE or on the HOLD handshake cycle, and abort always wins.
    assign accept_start = bus.start && !bus.abort &&
                          ((state == S_IDLE) || ((state == S_HOLD) && bus.out_ready));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            round_cnt   <= '0;
            col_cnt     <= '0;
            mode_q      <= 1'b0;
            start_err_q <= 1'b0;
            done_pend   <= 1'b0;
        end else begin
            start_err_q <= bus.start && !accept_start;
            done_pend   <= 1'b0;
            if (bus.abort) begin
                state     <= S_IDLE;
                round_cnt <= '0;
                col_cnt   <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept_start) begin
                            mode_q <= bus.opt_mode;
                            state  <= bus.key_ready ? S_LOAD : S_KEY_WAIT;
                        end
                    end
                    S_KEY_WAIT: begin
                        if (bus.key_ready) state <= S_LOAD;
                    end
                    S_LOAD: begin
                        round_cnt <= 4'd1;
                        col_cnt   <= '0;
                        state     <= S_ROUND;
                    end
                    S_ROUND: begin
                        if (col_cnt == LAST_COL) begin
                            col_cnt <= '0;
                            if (round_cnt == LAST_ROUND) begin
                                round_cnt <= '0;
                                done_pend <= 1'b1;
                                state     <= S_HOLD;
                            end else begin
                                round_cnt <= round_cnt + 4'd1;
                            end
                        end else begin
                            col_cnt <= col_cnt + 2'd1;
                        end
                    end
                    S_HOLD: begin
                        if (bus.out_ready) begin
                            if (accept_start) begin
                                mode_q <= bus.opt_mode;
                                state  <= bus.key_ready ? S_LOAD : S_KEY_WAIT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.busy        = (state != S_IDLE);
        bus.load_state  = 1'b0;
        bus.round_en    = 1'b0;
        bus.col_sel     = '0;
        bus.round_idx   = '0;
        bus.key_idx     = '0;
        bus.final_round = 1'b0;
        bus.out_valid   = 1'b0;
        bus.enc_done    = 1'b0;
        bus.start_err   = start_err_q;
        unique case (state)
            S_LOAD: begin
                bus.load_state = 1'b1;
                bus.key_idx    = mode_q ? LAST_ROUND : '0;
            end
            S_ROUND: begin
                bus.round_en    = 1'b1;
                bus.col_sel     = col_cnt;
                bus.round_idx   = round_cnt;
                bus.key_idx     = mode_q ? (LAST_ROUND - round_cnt) : round_cnt;
                bus.final_round = (round_cnt == LAST_ROUND);
            end
            S_HOLD: begin
                bus.out_valid = 1'b1;
                bus.enc_done  = done_pend;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed test-plan scenarios plus
// randomized traffic against a step-count reference model.
module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam int RC = 4;
    localparam int ROUND_STEPS = NR * RC;

    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    aes_round_sequencer_if bus();

    aes_round_sequencer #(
        .NUM_ROUNDS  (NR),
        .ROUND_CYCLES(RC)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    // Phase codes of the reference: 0 idle, 1 key wait, 2 load, 3 rounds, 4 hold
    function automatic logic [16:0] exp_vec(int ph, bit mode, int s, bit first, bit err);
        logic [1:0] col = '0;
        logic [3:0] rnd = '0;
        logic [3:0] key = '0;
        bit ld = 0, re = 0, fin = 0, ov = 0, ed = 0;
        case (ph)
            2: begin
                ld  = 1;
                key = mode ? 4'(NR) : 4'd0;
            end
            3: begin
                re  = 1;
                col = 2'(s % RC);
                rnd = 4'(s / RC + 1);
                key = mode ? 4'(NR - (s / RC + 1)) : rnd;
                fin = ((s / RC + 1) == NR);
            end
            4: begin
                ov = 1;
                ed = first;
            end
            default: ;
        endcase
        return {ph != 0, ld, re, col, rnd, key, fin, ov, ed, err};
    endfunction

    function automatic logic [16:0] obs();
        return {bus.busy, bus.load_state, bus.round_en, bus.col_sel, bus.round_idx,
                bus.key_idx, bus.final_round, bus.out_valid, bus.enc_done, bus.start_err};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] e;
        n_rst = 1'b0;
        bus.start = 0; bus.opt_mode = 0; bus.key_ready = 0; bus.abort = 0; bus.out_ready = 0;
        #3;
        e = '0;
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_asserted: got %h expected %h", obs(), e);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        next();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_released: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_basic_modes();
        logic [16:0] e;
        for (int m = 0; m < 2; m++) begin
            bus.start = 1; bus.opt_mode = 1'(m); bus.key_ready = 1; bus.out_ready = 1;
            for (int c = 1; c <= 43; c++) begin
                next();
                bus.start = 0;
                bus.opt_mode = 1'(~m);
                if (c == 1)       e = exp_vec(2, 1'(m), 0, 0, 0);
                else if (c <= 41) e = exp_vec(3, 1'(m), c - 2, 0, 0);
                else if (c == 42) e = exp_vec(4, 1'(m), 0, 1, 0);
                else              e = exp_vec(0, 0, 0, 0, 0);
                n_checks++;
                if (obs() !== e) begin
                    n_fail++;
                    $display("FAIL mode%0d cycle %0d: got %h expected %h", m, c, obs(), e);
                end
            end
        end
    endtask

    task automatic test_key_wait();
        logic [16:0] e;
        bus.start = 1; bus.opt_mode = 0; bus.key_ready = 0; bus.out_ready = 1;
        for (int c = 1; c <= 48; c++) begin
            next();
            bus.start = 0;
            if (c == 5)  bus.key_ready = 1;
            if (c == 20) bus.key_ready = 0;
            if (c <= 5)       e = exp_vec(1, 0, 0, 0, 0);
            else if (c == 6)  e = exp_vec(2, 0, 0, 0, 0);
            else if (c <= 46) e = exp_vec(3, 0, c - 7, 0, 0);
            else if (c == 47) e = exp_vec(4, 0, 0, 1, 0);
            else              e = exp_vec(0, 0, 0, 0, 0);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL key_wait cycle %0d: got %h expected %h", c, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        bus.start = 1; bus.opt_mode = 0; bus.key_ready = 1; bus.out_ready = 0;
        for (int c = 1; c <= 88; c++) begin
            next();
            bus.start = 0;
            if (c == 45) begin
                bus.out_ready = 1; bus.start = 1; bus.opt_mode = 1;
            end
            if (c <= 41 && c >= 2) e = exp_vec(3, 0, c - 2, 0, 0);
            else if (c == 1)       e = exp_vec(2, 0, 0, 0, 0);
            else if (c <= 45)      e = exp_vec(4, 0, 0, c == 42, 0);
            else if (c == 46)      e = exp_vec(2, 1, 0, 0, 0);
            else if (c <= 86)      e = exp_vec(3, 1, c - 47, 0, 0);
            else if (c == 87)      e = exp_vec(4, 1, 0, 1, 0);
            else                   e = exp_vec(0, 0, 0, 0, 0);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, obs(), e);
            end
        end
    endtask

    task automatic test_start_err_abort();
        logic [16:0] e;
        bus.start = 1; bus.opt_mode = 0; bus.key_ready = 1; bus.out_ready = 1;
        for (int c = 1; c <= 45; c++) begin
            next();
            bus.start = (c == 10);
            bus.opt_mode = (c == 10);
            bus.abort = (c == 20);
            if (c == 1)       e = exp_vec(2, 0, 0, 0, 0);
            else if (c <= 20) e = exp_vec(3, 0, c - 2, 0, c == 11);
            else              e = exp_vec(0, 0, 0, 0, 0);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL start_err_abort cycle %0d: got %h expected %h", c, obs(), e);
            end
        end
    endtask

    task automatic test_abort_start_idle();
        logic [16:0] e;
        bus.start = 1; bus.abort = 1; bus.key_ready = 1;
        next();
        bus.start = 0; bus.abort = 0;
        e = exp_vec(0, 0, 0, 0, 1);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL abort_start_idle: got %h expected %h", obs(), e);
        end
        next();
        e = exp_vec(0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL abort_start_idle_after: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] e;
        bus.start = 1; bus.opt_mode = 1; bus.key_ready = 1; bus.out_ready = 1;
        next();
        bus.start = 0;
        repeat (14) next();
        #2;
        n_rst = 1'b0;
        #1;
        e = '0;
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL async_reset_mid_round: got %h expected %h", obs(), e);
        end
        @(negedge clk);
        n_rst = 1'b1;
        next();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL async_reset_release: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_random();
        int  ph = 0, s = 0;
        bit  mode = 0, first = 0, err = 0;
        bit  st, om, kr, ab, ordy, acc;
        logic [16:0] e;
        for (int c = 0; c < 4000; c++) begin
            e = exp_vec(ph, mode, s, first, err);
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", c, obs(), e);
            end
            st   = ($urandom_range(7) == 0);
            om   = 1'($urandom);
            kr   = ($urandom_range(3) != 0);
            ab   = ($urandom_range(199) == 0);
            ordy = 1'($urandom);
            bus.start = st; bus.opt_mode = om; bus.key_ready = kr;
            bus.abort = ab; bus.out_ready = ordy;
            acc   = st && !ab && (ph == 0 || (ph == 4 && ordy));
            err   = st && !acc;
            first = 0;
            if (ab) ph = 0;
            else case (ph)
                0: if (st) begin mode = om; ph = kr ? 2 : 1; end
                1: if (kr) ph = 2;
                2: begin ph = 3; s = 0; end
                3: begin
                    s++;
                    if (s == ROUND_STEPS) begin ph = 4; first = 1; end
                end
                4: if (ordy) begin
                    if (st) begin mode = om; ph = kr ? 2 : 1; end
                    else ph = 0;
                end
                default: ph = 0;
            endcase
            next();
        end
        bus.start = 0; bus.abort = 0;
    endtask

    initial begin
        test_reset();
        test_basic_modes();
        test_key_wait();
        test_back_to_back();
        test_start_err_abort();
        test_abort_start_idle();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative round scheduler for the AES core (AESctr datapath).
- On a start pulse from the top-level controller, it waits for the expanded key schedule, issues the initial load/AddRoundKey, then steps the column-serial round datapath through NUM_ROUNDS rounds.
- Generates round index, round-key index (ascending for encrypt, descending for decrypt), column select and last-round flag.
- Holds the result under a valid/ready handshake and pulses enc_done back to the controller.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds (10 for AES-128); legal 1..15.
- ROUND_CYCLES, 4, datapath cycles per round (one column per cycle); legal 1..4.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to process the block currently in the shift register
- opt_mode  in  1  0 = encrypt, 1 = decrypt; sampled only when start is accepted
- key_ready  in  1  round-key schedule valid (from GenKey)
- abort  in  1  synchronous cancel, highest priority
- out_ready  in  1  consumer accepts the result block
- busy  out  1  high in every state except IDLE
- load_state  out  1  load input block into state register and apply initial AddRoundKey
- round_en  out  1  datapath advances one column-step
- col_sel  out  2  column being processed (0..ROUND_CYCLES-1)
- round_idx  out  4  current round number (1..NUM_ROUNDS)
- key_idx  out  4  round-key index presented to key storage
- final_round  out  1  current round is the last one; datapath bypasses MixColumns
- out_valid  out  1  result block valid
- enc_done  out  1  one-cycle pulse, first cycle of HOLD
- start_err  out  1  registered one-cycle pulse: start arrived while the block could not accept it

Behaviour:
- Reset: state=IDLE, counters 0, mode_q=0, start_err=0. All other outputs are 0 in IDLE.
- All outputs except start_err are decoded combinationally from registered state, counters and mode_q.
- States: IDLE, KEY_WAIT, LOAD, ROUND, HOLD.
- IDLE:
  - start → latch mode_q=opt_mode.
  - If key_ready → LOAD, else → KEY_WAIT.
- KEY_WAIT: stay until key_ready=1 → LOAD.
- LOAD (exactly 1 cycle):
  - load_state=1; key_idx = mode_q ? NUM_ROUNDS : 0; round_idx=0.
  - Next cycle: round_cnt=1, col_cnt=0 → ROUND.
- ROUND:
  - Outputs: round_en=1; col_sel=col_cnt; round_idx=round_cnt; key_idx = mode_q ? NUM_ROUNDS-round_cnt : round_cnt; final_round=(round_cnt==NUM_ROUNDS).
  - Each cycle col_cnt increments. At col_cnt==ROUND_CYCLES-1, col_cnt wraps to 0 and round_cnt increments.
  - On the last column of round NUM_ROUNDS → HOLD.
  - With ROUND_CYCLES=1, col_sel stays 0 and round_cnt increments every cycle.
- key_ready is ignored after LOAD; deassertion mid-round has no effect.
- HOLD:
  - out_valid=1 until out_valid&&out_ready, then → IDLE.
  - enc_done=1 only in the first HOLD cycle.
  - Back-to-back: if start=1 in the same cycle as the handshake, the start is accepted (mode_q relatched). Next state is LOAD if key_ready, else KEY_WAIT; IDLE is skipped.
- Latency (defaults, key_ready high): start accepted at cycle 0 → LOAD at cycle 1 → ROUND cycles 2..41 (40 cycles) → HOLD/out_valid/enc_done at cycle 42.
- start_err: set for one cycle following any cycle with start=1 where start was not accepted. This covers KEY_WAIT, LOAD, ROUND, HOLD without a handshake, and the abort case below. Ignored starts do not alter mode_q or the sequence.
- abort:
  - From any state → IDLE next cycle; counters cleared; no enc_done; result discarded.
  - abort and start together in IDLE: abort wins, start is dropped and start_err pulses.
  - abort in HOLD during the handshake: abort wins; no back-to-back start.
- Asynchronous reset mid-operation returns immediately to reset values; no pulses are generated.
- Counter widths: round_cnt 4 bits, col_cnt 2 bits. No wrap beyond NUM_ROUNDS is reachable.

Test Plan:
- Encrypt, key_ready=1, start at cycle 0, out_ready=1 → load_state at cycle 1; key_idx 1,1,1,1,2,…,10 across cycles 2–41; final_round high on cycles 38–41; out_valid and enc_done at cycle 42; IDLE at cycle 43.
- Decrypt, opt_mode=1 → key_idx=10 at LOAD, then 9 (×4 cycles) down to 0 (×4 cycles); final_round on the key_idx=0 cycles.
- key_ready=0 at start, raised at cycle 5 → KEY_WAIT cycles 1–5, load_state at cycle 6, out_valid at cycle 47; key_ready dropped at cycle 20 has no effect.
- out_ready=0 for 3 HOLD cycles → out_valid held for 4 cycles, enc_done one cycle only; start at handshake cycle with key_ready=1 → load_state the next cycle, busy never drops.
- start pulsed in ROUND (cycle 10) → start_err at cycle 11, sequence unchanged. abort at cycle 20 → IDLE at cycle 21, no enc_done, busy=0.
- abort+start together in IDLE → stays IDLE, start_err pulse; n_rst asserted in ROUND → all outputs 0 immediately.
